// File: rtl/pmod_report_pkg.sv
// Shared types and helpers for the PMOD change reporter: serializer state
// encoding, the newline terminator and nibble-to-ASCII conversion.
package pmod_report_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam logic [7:0] ASCII_NL = 8'h0A;

  // Uppercase hex digit: 0-9 -> 0x30-0x39, A-F -> 0x41-0x46.
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end
    return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/pmod_report_tx_uart.sv
// 8N1 byte serializer with a registered line output; a new byte may be
// chained from the final stop-bit cycle so consecutive bytes have no gap.
module uart_tx_byte
  import pmod_report_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       in_clock,
  input  logic       in_reset,
  input  logic       in_start,
  input  logic [7:0] in_data,
  output logic       out_tx,
  output logic       out_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);

  // Handshake: in_start/in_data are accepted only in IDLE or in the cycle
  // out_done is high (last stop-bit cycle); out_done is a one-cycle pulse.
  tx_state_e     state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          bit_end;

  assign bit_end = (baud_q == BAUD_MAX);
  assign out_tx  = tx_q;

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    out_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (in_start) begin
          state_d = ST_START;
          shift_d = in_data;
          baud_d  = '0;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          baud_d  = '0;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          out_done = 1'b1;
          baud_d   = '0;
          if (in_start) begin
            state_d = ST_START;
            shift_d = in_data;
            tx_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/pmod_report_tx.sv
// Watches the synchronized PMOD nibble and, on change, reports it over UART
// as an ASCII hex digit followed by a newline.
module pmod_report_tx
  import pmod_report_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       in_clock,
  input  logic       in_reset,
  input  logic [3:0] in_pmod,
  output logic       out_tx,
  output logic       out_busy,
  output logic [7:0] out_count
);

  logic [3:0] sync1_q, sync_q;
  logic [3:0] reported_q, reported_d;
  logic       busy_q, busy_d;
  logic       byte_idx_q, byte_idx_d;
  logic [7:0] count_q, count_d;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done;

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      sync1_q <= 4'h0;
      sync_q  <= 4'h0;
    end else begin
      sync1_q <= in_pmod;
      sync_q  <= sync1_q;
    end
  end

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      reported_q <= 4'h0;
      busy_q     <= 1'b0;
      byte_idx_q <= 1'b0;
      count_q    <= 8'h00;
    end else begin
      reported_q <= reported_d;
      busy_q     <= busy_d;
      byte_idx_q <= byte_idx_d;
      count_q    <= count_d;
    end
  end

  // Idle re-compare happens in the single cycle after the last stop bit, so
  // a change seen during busy is reported once with the latest value.
  always_comb begin
    reported_d = reported_q;
    busy_d     = busy_q;
    byte_idx_d = byte_idx_q;
    count_d    = count_q;
    tx_start   = 1'b0;
    tx_data    = ASCII_NL;
    if (!busy_q) begin
      if (sync_q != reported_q) begin
        tx_start   = 1'b1;
        tx_data    = hex_ascii(sync_q);
        reported_d = sync_q;
        busy_d     = 1'b1;
        byte_idx_d = 1'b0;
      end
    end else if (tx_done) begin
      if (!byte_idx_q) begin
        tx_start   = 1'b1;
        tx_data    = ASCII_NL;
        byte_idx_d = 1'b1;
      end else begin
        busy_d     = 1'b0;
        byte_idx_d = 1'b0;
        count_d    = count_q + 8'd1;
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .in_clock (in_clock),
    .in_reset (in_reset),
    .in_start (tx_start),
    .in_data  (tx_data),
    .out_tx   (out_tx),
    .out_done (tx_done)
  );

  assign out_busy  = busy_q;
  assign out_count = count_q;

endmodule

// File: doc/pmod_report_tx.md
PMOD_REPORT_TX -- requirements
Module: pmod_report_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104, meaning clock cycles per UART bit (12 MHz / 115200 baud).
REQ-002 SHALL have port in_clock  input  1  system clock; all state is updated on its rising edge.
REQ-003 SHALL have port in_reset  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port in_pmod  input  4  raw PMOD pins [3:0], asynchronous to in_clock.
REQ-005 SHALL have port out_tx  output  1  UART transmit line, idle high, 8N1, LSB first.
REQ-006 SHALL have port out_busy  output  1  high while a report frame pair is being transmitted.
REQ-007 SHALL have port out_count  output  8  number of completed reports, wrapping modulo 256.

Function
REQ-008 SHALL pass in_pmod through a 2-flop synchronizer; only the synchronized value (sync) is used downstream.
REQ-009 SHALL hold a 4-bit register "reported" holding the last value sent.
REQ-010 SHALL, in IDLE, detect sync != reported in cycle N, capture sync into reported in cycle N, and drive out_tx low (start bit) from cycle N+1.
REQ-011 SHALL send each report as two bytes back-to-back: the ASCII uppercase hex digit of the captured nibble (0x30-0x39, 0x41-0x46), then 0x0A.
REQ-012 SHALL frame each byte as start bit 0, data bits 0..7, stop bit 1, with each bit held exactly CLKS_PER_BIT cycles.
REQ-013 SHALL start the second byte's start bit in the cycle immediately after the first byte's stop bit ends, with no idle gap.
REQ-014 SHALL assert out_busy from cycle N+1 through the last stop-bit cycle, i.e. 20*CLKS_PER_BIT cycles.
REQ-015 SHALL increment out_count in the cycle after the final stop bit completes.
REQ-016 SHALL ignore changes of sync while busy; the nibble in flight stays the captured value.
REQ-017 SHALL, on return to IDLE, spend exactly one idle cycle with out_tx high, then re-compare sync against reported, so a change during busy is reported once with the current (latest) value.
REQ-018 SHALL send nothing when sync returns to the reported value before IDLE re-compare, i.e. a glitch fully contained in a busy window.
REQ-019 SHALL implement states IDLE, START, DATA, STOP plus a 1-bit byte index (0 = hex digit, 1 = newline).
REQ-020 SHALL sequence the states as: IDLE->START on change; START->DATA after CLKS_PER_BIT; DATA->STOP after 8 bits; STOP->START if byte index = 0, else STOP->IDLE.
REQ-021 SHALL use a baud counter of width ceil(log2(CLKS_PER_BIT)) that reloads at each bit boundary.
REQ-022 SHALL accept CLKS_PER_BIT values of 2 or more.

Reset
REQ-023 SHALL, on in_reset high, immediately set out_tx=1, out_busy=0, out_count=0, reported=4'h0, synchronizer flops=0, state=IDLE, byte index=0, baud and bit counters=0.
REQ-024 SHALL, on reset mid-frame, abort the frame with out_tx high from the reset edge; a truncated byte is acceptable.
REQ-025 SHALL, after reset release with in_pmod nonzero, send a report once the synchronizer settles (cycle N = 2 cycles after release).

Structure
REQ-026 SHALL place the state enum, ASCII_NL (0x0A), and the hex-to-ASCII function in shared package pmod_report_pkg.
REQ-027 SHALL use one sub-module uart_tx_byte (ports in_clock, in_reset, in_start, in_data[7:0], out_tx, out_done) for byte serialization; pmod_report_tx sequences the two bytes and the change detection.

Verification (CLKS_PER_BIT=4)
REQ-028 SHALL cover: hold in_pmod=0 after reset for 200 cycles -> out_tx constant 1, out_busy 0, out_count 0.
REQ-029 SHALL cover: in_pmod 0->4'hA -> line decodes 0x41 then 0x0A, out_busy high 80 cycles, out_count=1.
REQ-030 SHALL cover: in_pmod=4'h3, then 4'h5 at busy+10, then 4'h7 at busy+30 -> exactly two reports, '3' then '7', out_count=2.
REQ-031 SHALL cover: in_pmod=4'h1, then 4'h0 mid-frame, then back to 4'h1 before end -> one report '1' only.
REQ-032 SHALL cover: assert in_reset during data bit 3 of the first byte -> out_tx=1 and out_busy=0 at the reset edge; with in_pmod=4'hF held, a fresh '\F',0x0A report after release.
REQ-033 SHALL cover: 256 alternating 4'h0/4'h1 reports -> out_count wraps 0xFF->0x00.
